// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation request in, results and status out.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             z;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output start, op, a, b,
        input  ready, done, s, z, hi, lo, dz
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, s, z, hi, lo, dz
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops, plus iterative multiply
// (shift-add) and restoring divide at one bit per cycle, finished by a sign-fix cycle.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     resetn,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1111;

    if ((WIDTH % 2) != 0 || WIDTH < 8) begin : g_bad_width
        $error("alu_seq: WIDTH must be even and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return negate_if(x, sgn && x[WIDTH-1]);
    endfunction

    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] f,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        logic [CW-1:0]           sh;
        sx = x;
        sy = y;
        sh = x[CW-1:0];
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_LUI:  return y << (WIDTH / 2);
            OP_SLL:  return y << sh;
            OP_SRL:  return y >> sh;
            OP_SRA:  return sy >>> sh;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sx < sy)};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (x < y)};
            default: return '0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ready, go_single, load, fin;
    logic                   op_long, op_mul, op_sgn, b_zero;

    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       m_q, m_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic                   neg_q, neg_d, negr_q, negr_d;
    logic                   div_q, div_d, dz0_q, dz0_d;

    logic [WIDTH:0]         mul_sum, div_t;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_rem;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       single_res;

    logic [WIDTH-1:0]       s_q, s_d, hi_q, hi_d, lo_q, lo_d;
    logic                   z_q, z_d, dz_q, dz_d, done_q, done_d;

    // Long ops are 10xx: bit 1 selects divide, bit 0 selects unsigned.
    assign op_long    = bus.op[3:2] == 2'b10;
    assign op_mul     = ~bus.op[1];
    assign op_sgn     = ~bus.op[0];
    assign b_zero     = bus.b == '0;
    assign single_res = alu_single(bus.op, bus.a, bus.b);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start && op_long) begin
                    if (op_mul) begin
                        state_d = MUL;
                        cnt_d   = CW'(WIDTH - 1);
                    end else if (b_zero) begin
                        state_d = FIX;
                    end else begin
                        state_d = DIV;
                        cnt_d   = CW'(WIDTH - 1);
                    end
                end
            end
            MUL, DIV: begin
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = state_q == IDLE;
        go_single = ready && bus.start && !op_long;
        load      = ready && bus.start && op_long;
        fin       = state_q == FIX;
    end

    // acc holds {partial product high, multiplier} or {partial remainder, dividend/quotient}.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign div_t   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = div_t >= {1'b0, m_q};
    assign div_rem = div_ge ? WIDTH'(div_t - {1'b0, m_q}) : div_t[WIDTH-1:0];
    assign prod    = neg_q ? -acc_q : acc_q;

    always_comb begin
        acc_d  = acc_q;
        m_d    = m_q;
        a_d    = a_q;
        neg_d  = neg_q;
        negr_d = negr_q;
        div_d  = div_q;
        dz0_d  = dz0_q;
        if (load) begin
            a_d    = bus.a;
            neg_d  = op_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negr_d = op_sgn && bus.a[WIDTH-1];
            div_d  = !op_mul;
            dz0_d  = !op_mul && b_zero;
            if (op_mul) begin
                acc_d = {{WIDTH{1'b0}}, magnitude(bus.b, op_sgn)};
                m_d   = magnitude(bus.a, op_sgn);
            end else begin
                acc_d = {{WIDTH{1'b0}}, magnitude(bus.a, op_sgn)};
                m_d   = magnitude(bus.b, op_sgn);
            end
        end else if (state_q == MUL) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (state_q == DIV) begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clock) begin
        acc_q  <= acc_d;
        m_q    <= m_d;
        a_q    <= a_d;
        neg_q  <= neg_d;
        negr_q <= negr_d;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q <= 1'b0;
            dz0_q <= 1'b0;
        end else begin
            div_q <= div_d;
            dz0_q <= dz0_d;
        end
    end

    always_comb begin
        done_d = go_single || fin;
        s_d    = s_q;
        z_d    = z_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        if (go_single) begin
            s_d = single_res;
            z_d = single_res == '0;
        end else if (fin) begin
            if (dz0_q) begin
                lo_d = '1;
                hi_d = a_q;
            end else if (div_q) begin
                lo_d = negate_if(acc_q[WIDTH-1:0], neg_q);
                hi_d = negate_if(acc_q[2*WIDTH-1:WIDTH], negr_q);
            end else begin
                lo_d = prod[WIDTH-1:0];
                hi_d = prod[2*WIDTH-1:WIDTH];
            end
            s_d = lo_d;
            z_d = lo_d == '0;
            if (div_q) dz_d = dz0_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_q    <= '0;
            z_q    <= 1'b1;
            hi_q   <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            z_q    <= z_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    assign bus.ready = ready;
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.z     = z_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.dz    = dz_q;
endmodule
